// File: rtl/cpu_halt_monitor_pkg.sv
// -----------------------------------------------------------------------------
// cpu_halt_monitor_pkg
//
// Shared definitions for the CPU halt monitor and the benches that drive it:
//   - mon_state_t   : monitor state type plus its state constants
//   - STALL_LIMIT   : repeated-fetch count that counts as a hung CPU
//   - DEFAULT_RESET_VECTOR / DEFAULT_HALT_ADDR : default program bounds
//   - is_terminal() : true for the sticky end-of-run states
// -----------------------------------------------------------------------------
package cpu_halt_monitor_pkg;

  typedef logic [2:0] mon_state_t;

  localparam mon_state_t ST_IDLE          = 3'd0;
  localparam mon_state_t ST_RUN           = 3'd1;
  localparam mon_state_t ST_WAIT_INACTIVE = 3'd2;
  localparam mon_state_t ST_DONE_OK       = 3'd3;
  localparam mon_state_t ST_DONE_BAD      = 3'd4;
  localparam mon_state_t ST_TIMED_OUT     = 3'd5;
  localparam mon_state_t ST_FAULTED       = 3'd6;

  localparam int unsigned STALL_LIMIT = 64;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

  function automatic logic is_terminal(input mon_state_t s);
    return (s == ST_DONE_OK) || (s == ST_DONE_BAD) || (s == ST_TIMED_OUT) || (s == ST_FAULTED);
  endfunction

endpackage

// File: rtl/cpu_halt_monitor_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// Up-counter with synchronous clear and saturation at all-ones (never wraps).
// count_next exposes the value the counter will take at the next edge so the
// owner can make decisions on the post-increment count in the same cycle.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset, clears the count
//   clear      in   synchronous clear (wins over incr)
//   incr       in   increment by one this cycle (saturating)
//   count      out  current count
//   count_next out  value loaded at the next rising edge
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             incr,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next
);

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (incr && (count != {WIDTH{1'b1}})) begin
      count_next = count + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/cpu_halt_monitor.sv
// -----------------------------------------------------------------------------
// cpu_halt_monitor
//
// Watches the status outputs of mips_cpu_harvard for one program run: the run
// must start at RESET_VECTOR, fetch HALT_ADDR to end, and drop active within
// GRACE_CYCLES afterwards. $v0 is captured on the edge active falls and is
// compared with expected_v0. The outcome is held in a sticky terminal state
// until reset.
//
// Build option:
//   CPU_HALT_MONITOR_STALL_CHECK_EN - when defined, a fetch address repeated
//   for STALL_LIMIT consecutive enabled cycles in RUN is reported as a fault.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-high reset
//   clk_enable    in   CPU clock enable; the monitor only advances when high
//   active        in   CPU active flag
//   instr_address in   CPU fetch address
//   register_v0   in   CPU $v0
//   expected_v0   in   required $v0 at halt (static during a run)
//   done          out  run finished (any terminal state)
//   pass          out  finished with captured $v0 == expected_v0
//   timeout       out  run or grace budget exhausted
//   fault         out  bad start, misaligned fetch, early inactive or stall
//   result_v0     out  $v0 captured when active fell
//   cycle_count   out  enabled cycles spent in RUN and WAIT_INACTIVE
// -----------------------------------------------------------------------------
module cpu_halt_monitor
  import cpu_halt_monitor_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR      = DEFAULT_HALT_ADDR,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned GRACE_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        active,
  input  logic [31:0] instr_address,
  input  logic [31:0] register_v0,
  input  logic [31:0] expected_v0,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic        fault,
  output logic [31:0] result_v0,
  output logic [31:0] cycle_count
);

  localparam int unsigned GraceW = $clog2(GRACE_CYCLES + 1);

  mon_state_t  state_q, state_d;
  logic [31:0] result_q, result_d;

  logic              in_idle, in_run, in_wait;
  logic              start_ok, misaligned, halt_fetch;
  logic              cc_incr;
  logic [31:0]       cc_next;
  logic              grace_clr, grace_incr;
  logic [GraceW-1:0] grace, grace_next;
  logic              timeout_hit, grace_hit, stall_hit;

  assign in_idle    = (state_q == ST_IDLE);
  assign in_run     = (state_q == ST_RUN);
  assign in_wait    = (state_q == ST_WAIT_INACTIVE);
  assign start_ok   = active && (instr_address == RESET_VECTOR);
  assign misaligned = (instr_address[1:0] != 2'b00);
  assign halt_fetch = (instr_address == HALT_ADDR);

  // The IDLE->RUN edge counts as the first run cycle, so the count is 1 on entry.
  assign cc_incr = clk_enable && (in_run || in_wait || (in_idle && start_ok));

  sat_counter #(
    .WIDTH (32)
  ) u_cycle_cnt (
    .clk        (clk),
    .reset      (reset),
    .clear      (1'b0),
    .incr       (cc_incr),
    .count      (cycle_count),
    .count_next (cc_next)
  );

  assign grace_clr  = clk_enable && in_run && halt_fetch;
  assign grace_incr = clk_enable && in_wait;

  sat_counter #(
    .WIDTH (GraceW)
  ) u_grace_cnt (
    .clk        (clk),
    .reset      (reset),
    .clear      (grace_clr),
    .incr       (grace_incr),
    .count      (grace),
    .count_next (grace_next)
  );

  // Limits are judged on the post-increment count, so the timeout flag and
  // cycle_count == TIMEOUT_CYCLES become visible on the same edge.
  assign timeout_hit = (cc_next == TIMEOUT_CYCLES);
  assign grace_hit   = (grace_next == GraceW'(GRACE_CYCLES));

`ifdef CPU_HALT_MONITOR_STALL_CHECK_EN
  logic [31:0] prev_addr_q;
  logic [15:0] stall, stall_next;
  logic        addr_same;

  assign addr_same = (instr_address == prev_addr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_addr_q <= '0;
    end else if (clk_enable) begin
      prev_addr_q <= instr_address;
    end
  end

  sat_counter #(
    .WIDTH (16)
  ) u_stall_cnt (
    .clk        (clk),
    .reset      (reset),
    .clear      (clk_enable && in_run && !addr_same),
    .incr       (clk_enable && in_run && addr_same),
    .count      (stall),
    .count_next (stall_next)
  );

  assign stall_hit = in_run && (stall_next == 16'(STALL_LIMIT));
`else
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    if (clk_enable) begin
      case (state_q)
        ST_IDLE: begin
          if (active) begin
            state_d = start_ok ? ST_RUN : ST_FAULTED;
          end
        end
        ST_RUN: begin
          // Fault beats halt beats timeout.
          if (!active || misaligned || stall_hit) begin
            state_d = ST_FAULTED;
          end else if (halt_fetch) begin
            state_d = ST_WAIT_INACTIVE;
          end else if (timeout_hit) begin
            state_d = ST_TIMED_OUT;
          end
        end
        ST_WAIT_INACTIVE: begin
          // Active falling wins over grace expiry on the same edge.
          if (!active) begin
            result_d = register_v0;
            state_d  = (register_v0 == expected_v0) ? ST_DONE_OK : ST_DONE_BAD;
          end else if (grace_hit) begin
            state_d = ST_TIMED_OUT;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign done      = is_terminal(state_q);
  assign pass      = (state_q == ST_DONE_OK);
  assign timeout   = (state_q == ST_TIMED_OUT);
  assign fault     = (state_q == ST_FAULTED);
  assign result_v0 = result_q;

endmodule

// File: tb/tb_cpu_halt_monitor.sv
module tb_cpu_halt_monitor;
  import cpu_halt_monitor_pkg::*;

`ifdef CPU_HALT_MONITOR_STALL_CHECK_EN
  localparam int unsigned TO = 200;
`else
  localparam int unsigned TO = 20;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        active;
  logic [31:0] instr_address;
  logic [31:0] register_v0;
  logic [31:0] expected_v0;
  logic        done, pass, timeout, fault;
  logic [31:0] result_v0, cycle_count;

  always #5 clk = ~clk;

  cpu_halt_monitor #(
    .RESET_VECTOR   (DEFAULT_RESET_VECTOR),
    .HALT_ADDR      (DEFAULT_HALT_ADDR),
    .TIMEOUT_CYCLES (TO),
    .GRACE_CYCLES   (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .active        (active),
    .instr_address (instr_address),
    .register_v0   (register_v0),
    .expected_v0   (expected_v0),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .fault         (fault),
    .result_v0     (result_v0),
    .cycle_count   (cycle_count)
  );

  typedef struct {
    int          tag;
    logic        pass_e;
    logic        timeout_e;
    logic        fault_e;
    logic [31:0] result_e;
    logic [31:0] cc_e;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   done_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input int tag, input logic p, input logic t, input logic f,
                      input logic [31:0] r, input logic [31:0] c);
    exp_t e;
    e.tag = tag; e.pass_e = p; e.timeout_e = t; e.fault_e = f; e.result_e = r; e.cc_e = c;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation on every rising of done.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      done_seen <= 1'b0;
    end else if (done && !done_seen) begin
      done_seen <= 1'b1;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("run%0d_pass", e.tag), 32'(pass), 32'(e.pass_e));
        chk($sformatf("run%0d_timeout", e.tag), 32'(timeout), 32'(e.timeout_e));
        chk($sformatf("run%0d_fault", e.tag), 32'(fault), 32'(e.fault_e));
        chk($sformatf("run%0d_result_v0", e.tag), result_v0, e.result_e);
        chk($sformatf("run%0d_cycle_count", e.tag), cycle_count, e.cc_e);
      end
    end
  end

  task automatic cyc(input logic a, input logic [31:0] addr, input logic [31:0] v0);
    active = a; instr_address = addr; register_v0 = v0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk($sformatf("run%0d_done_seen", tag), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    active = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic normal_run(input int tag, input logic [31:0] exp_v0, input logic [31:0] v0);
    expected_v0 = exp_v0;
    push(tag, v0 == exp_v0, 1'b0, 1'b0, v0, 32'd5);
    cyc(1'b1, 32'hBFC0_0000, 32'd0);
    cyc(1'b1, 32'hBFC0_0004, 32'd0);
    cyc(1'b1, 32'hBFC0_0008, 32'd0);
    cyc(1'b1, 32'h0000_0000, 32'd0);
    cyc(1'b0, 32'h0000_0000, v0);
    wait_empty(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clk_enable = 1'b1; active = 1'b0;
    instr_address = '0; register_v0 = '0; expected_v0 = '0;
    @(negedge clk);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_pass", 32'(pass), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_result_v0", result_v0, 32'd0);
    chk("reset_cycle_count", cycle_count, 32'd0);
    do_reset();

    // 1: clean pass, 2: wrong result
    normal_run(1, 32'd2, 32'd2);
    do_reset();
    normal_run(2, 32'd2, 32'd3);
    do_reset();

    // 3: loop without halting -> timeout with cycle_count == TO
    push(3, 1'b0, 1'b1, 1'b0, 32'd0, 32'(TO));
    cyc(1'b1, 32'hBFC0_0000, 32'd0);
    for (int i = 0; i < int'(TO) + 3; i++) begin
      cyc(1'b1, (i % 2 == 0) ? 32'hBFC0_0004 : 32'hBFC0_0000, 32'd0);
    end
    wait_empty(3);
    do_reset();

    // 4: bad start address
    push(4, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    cyc(1'b1, 32'hBFC0_0010, 32'd0);
    wait_empty(4);
    do_reset();

    // 5: misaligned fetch in RUN
    push(5, 1'b0, 1'b0, 1'b1, 32'd0, 32'd3);
    cyc(1'b1, 32'hBFC0_0000, 32'd0);
    cyc(1'b1, 32'hBFC0_0004, 32'd0);
    cyc(1'b1, 32'hBFC0_0006, 32'd0);
    wait_empty(5);
    do_reset();

    // 6: active stays high for the full grace window
    push(6, 1'b0, 1'b1, 1'b0, 32'd0, 32'd6);
    cyc(1'b1, 32'hBFC0_0000, 32'd0);
    cyc(1'b1, 32'h0000_0000, 32'd0);
    repeat (4) cyc(1'b1, 32'h0000_0000, 32'd0);
    wait_empty(6);
    do_reset();

    // 7: active falls on the edge the grace limit expires -> active wins
    expected_v0 = 32'd2;
    push(7, 1'b1, 1'b0, 1'b0, 32'd2, 32'd6);
    cyc(1'b1, 32'hBFC0_0000, 32'd0);
    cyc(1'b1, 32'h0000_0000, 32'd0);
    repeat (3) cyc(1'b1, 32'h0000_0000, 32'd0);
    cyc(1'b0, 32'h0000_0000, 32'd2);
    wait_empty(7);
    do_reset();

    // 8: clk_enable low mid-run freezes everything
    expected_v0 = 32'd7;
    push(8, 1'b1, 1'b0, 1'b0, 32'd7, 32'd5);
    cyc(1'b1, 32'hBFC0_0000, 32'd0);
    cyc(1'b1, 32'hBFC0_0004, 32'd0);
    clk_enable = 1'b0;
    for (int i = 0; i < 10; i++) cyc(i[0], 32'hBFC0_0006, 32'd0);
    chk("hold_cycle_count", cycle_count, 32'd2);
    chk("hold_fault", 32'(fault), 32'd0);
    clk_enable = 1'b1;
    cyc(1'b1, 32'hBFC0_0008, 32'd0);
    cyc(1'b1, 32'h0000_0000, 32'd0);
    cyc(1'b0, 32'h0000_0000, 32'd7);
    wait_empty(8);
    do_reset();

    // 9: asynchronous reset at cycle 7, then a clean run
    cyc(1'b1, 32'hBFC0_0000, 32'd0);
    for (int i = 1; i < 7; i++) cyc(1'b1, 32'hBFC0_0000 + 32'(4 * i), 32'd0);
    chk("pre_reset_cycle_count", cycle_count, 32'd7);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_cycle_count", cycle_count, 32'd0);
    chk("async_reset_done", 32'(done), 32'd0);
    chk("async_reset_result_v0", result_v0, 32'd0);
    @(posedge clk);
    #1;
    active = 1'b0;
    reset = 1'b0;
    normal_run(9, 32'd2, 32'd2);
    do_reset();

`ifdef CPU_HALT_MONITOR_STALL_CHECK_EN
    // 10: address held in RUN until the stall limit trips
    push(10, 1'b0, 1'b0, 1'b1, 32'd0, 32'd66);
    cyc(1'b1, 32'hBFC0_0000, 32'd0);
    repeat (70) cyc(1'b1, 32'hBFC0_0004, 32'd0);
    wait_empty(10);
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
